seg7_scan_driver: RTL and testbench

Parametrised, time-multiplexed driver for a bank of 7-segment digits on the scoreboard. It holds a shadow copy of DIGITS BCD nibbles plus decimal points and scans them one digit at a time onto a shared segment bus. It adds three things over the plain combinational decoder: a prescaled scan counter, a one-hot digit select, and an anti-ghosting guard interval. It sits between the score/timer counters and the board pins.

---
 rtl/seg7_pkg.sv | 25 ++
 rtl/bcd_to_seg7.sv | 26 ++
 rtl/seg7_scan_driver.sv | 100 ++++++++++
 tb/tb_seg7_scan_driver.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared segment patterns (active-high, bit6=a .. bit0=g), index width and polarity helper
// for the multiplexed 7-segment scan driver.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_DASH  = 7'h01;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam int DIGITS_DEFAULT = 4;
  localparam int IDX_W          = $clog2(DIGITS_DEFAULT);

  function automatic logic [6:0] seg7_polarity(input logic [6:0] pat, input bit active_low);
    return active_low ? ~pat : pat;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-high a..g pattern; 10..15 show a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver: shadowed BCD digits, prescaled one-hot scan, blank guard.
// Optional leading-zero blanking when SEG7_LZB_EN is defined.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int PRESCALE   = 50000,
  parameter int GUARD      = 1,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [4*DIGITS-1:0]         bcd_in,
  input  logic [DIGITS-1:0]           dp_in,
  input  logic                        load,
  output logic [6:0]                  seg_out,
  output logic                        dp_out,
  output logic [DIGITS-1:0]           digit_en,
  output logic [$clog2(DIGITS)-1:0]   scan_idx
);

  localparam int IW    = $clog2(DIGITS);
  localparam int CNT_W = $clog2(PRESCALE);
  localparam logic [DIGITS-1:0] EN_OFF = {DIGITS{ACTIVE_LOW}};

  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [IW-1:0]       idx_nxt;
  logic [4*DIGITS-1:0] shadow_bcd, bcd_nxt;
  logic [DIGITS-1:0]   shadow_dp, dp_nxt;
  logic [DIGITS-1:0]   en_nxt;
  logic [3:0]          nib;
  logic                nib_dp;
  logic [6:0]          pat;
  logic                blank;
  logic                seg_upd;

  // Outputs are computed from next-state so pins move on the same edge as cnt/scan_idx.
  always_comb begin
    bcd_nxt = load ? bcd_in : shadow_bcd;
    dp_nxt  = load ? dp_in  : shadow_dp;
    if (cnt == CNT_W'(PRESCALE - 1)) begin
      cnt_nxt = '0;
      idx_nxt = (scan_idx == IW'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
    end else begin
      cnt_nxt = cnt + 1'b1;
      idx_nxt = scan_idx;
    end
    nib    = bcd_nxt[{idx_nxt, 2'b00} +: 4];
    nib_dp = dp_nxt[idx_nxt];
    en_nxt = '0;
    if (int'(cnt_nxt) >= GUARD) en_nxt[idx_nxt] = 1'b1;
    // Segments only refresh while the digit is dark, so a mid-slot load waits for the next slot.
    seg_upd = (int'(cnt_nxt) <= GUARD) || (digit_en == EN_OFF);
  end

`ifdef SEG7_LZB_EN
  logic [DIGITS-1:0] blank_vec;
  logic              zero_run;

  always_comb begin
    blank_vec = '0;
    zero_run  = 1'b1;
    for (int k = DIGITS - 1; k > 0; k--) begin
      zero_run     = zero_run && (bcd_nxt[4*k +: 4] == 4'd0);
      blank_vec[k] = zero_run;
    end
    blank = blank_vec[idx_nxt];
  end
`else
  assign blank = 1'b0;
`endif

  bcd_to_seg7 u_dec (
    .bcd (nib),
    .seg (pat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      scan_idx   <= '0;
      shadow_bcd <= '0;
      shadow_dp  <= '0;
      seg_out    <= seg7_polarity(SEG_BLANK, ACTIVE_LOW);
      dp_out     <= ACTIVE_LOW;
      digit_en   <= EN_OFF;
    end else begin
      cnt        <= cnt_nxt;
      scan_idx   <= idx_nxt;
      shadow_bcd <= bcd_nxt;
      shadow_dp  <= dp_nxt;
      digit_en   <= en_nxt ^ EN_OFF;
      if (seg_upd) begin
        seg_out <= seg7_polarity(blank ? SEG_BLANK : pat, ACTIVE_LOW);
        dp_out  <= (nib_dp & ~blank) ^ ACTIVE_LOW;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (DIGITS=4, PRESCALE=4, GUARD=1, ACTIVE_LOW=1);
// expectations follow SEG7_LZB_EN when it is defined.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  digit_en;
  logic [1:0]  scan_idx;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .DIGITS     (4),
    .PRESCALE   (4),
    .GUARD      (1),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bcd_in   (bcd_in),
    .dp_in    (dp_in),
    .load     (load),
    .seg_out  (seg_out),
    .dp_out   (dp_out),
    .digit_en (digit_en),
    .scan_idx (scan_idx)
  );

  // Expected {digit_en, seg_out, dp_out} while digit k is lit, all pins active-low.
  function automatic logic [11:0] exp_pins(input logic [15:0] v, input logic [3:0] d, input int k);
    logic [3:0] n;
    logic [6:0] s;
    logic [3:0] en;
    logic       blank;
    n  = v[4*k +: 4];
    en = 4'b0001;
    en = ~(en << k);
    case (n)
      4'd0: s = 7'h7E;  4'd1: s = 7'h30;  4'd2: s = 7'h6D;  4'd3: s = 7'h79;
      4'd4: s = 7'h33;  4'd5: s = 7'h5B;  4'd6: s = 7'h5F;  4'd7: s = 7'h70;
      4'd8: s = 7'h7F;  4'd9: s = 7'h7B;  default: s = 7'h01;
    endcase
    blank = 1'b0;
`ifdef SEG7_LZB_EN
    if (k > 0) begin
      blank = 1'b1;
      for (int j = k; j < 4; j++) if (v[4*j +: 4] != 4'd0) blank = 1'b0;
    end
`endif
    if (blank) return {en, 7'h7F, 1'b1};
    return {en, ~s, ~d[k]};
  endfunction

  // Records the lit cycles of the next four slots (no checking here).
  task automatic capture(output logic [143:0] obs, output logic [7:0] idxs, output bit tmo);
    int n;
    obs  = '0;
    idxs = '0;
    tmo  = 1'b0;
    for (int j = 0; j < 4; j++) begin
      n = 0;
      while (digit_en !== 4'hF && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (n >= 40) begin
        tmo = 1'b1;
        return;
      end
      idxs[2*j +: 2] = scan_idx;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        obs[(3*j + c)*12 +: 12] = {digit_en, seg_out, dp_out};
      end
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    bcd_in = v;
    dp_in  = d;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({digit_en, seg_out, dp_out} !== {4'hF, 7'h7F, 1'b1})
        $display("FAIL reset_pins got %h want %h", {digit_en, seg_out, dp_out}, {4'hF, 7'h7F, 1'b1});
      else passed++;
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({scan_idx, digit_en, seg_out, dp_out} !== {2'd0, 4'hE, 7'h01, 1'b1})
        $display("FAIL post_reset_slot0 got %h want %h", {scan_idx, digit_en, seg_out, dp_out}, {2'd0, 4'hE, 7'h01, 1'b1});
      else passed++;
    end
    @(negedge clk);
    total++;
    if ({scan_idx, digit_en} !== {2'd1, 4'hF})
      $display("FAIL guard_slot1 got %h want %h", {scan_idx, digit_en}, {2'd1, 4'hF});
    else passed++;
  endtask

  task automatic test_scan(input string name, input logic [15:0] v, input logic [3:0] d);
    logic [143:0] obs;
    logic [7:0]   idxs;
    bit           tmo;
    int           k;
    capture(obs, idxs, tmo);
    total++;
    if (tmo) $display("FAIL %s timeout got no guard want guard within 40 cycles", name);
    else passed++;
    for (int j = 0; j < 4; j++) begin
      k = (int'(idxs[1:0]) + j) % 4;
      total++;
      if (idxs[2*j +: 2] !== k[1:0])
        $display("FAIL %s slot_order j=%0d got %0d want %0d", name, j, idxs[2*j +: 2], k);
      else passed++;
      total++;
      if (obs[36*j +: 36] !== {3{exp_pins(v, d, k)}})
        $display("FAIL %s digit%0d got %h want %h", name, k, obs[36*j +: 36], {3{exp_pins(v, d, k)}});
      else passed++;
    end
  endtask

  task automatic test_no_tearing();
    bcd_in = 16'h9999;
    test_scan("no_load_hold", 16'h1234, 4'h0);
    do_load(16'h9999, 4'h0);
    test_scan("load_on_wrap", 16'h9999, 4'h0);
  endtask

  task automatic test_dash_and_dp();
    int k;
    @(negedge clk);
    @(negedge clk);
    k = int'(scan_idx);
    do_load(16'h00AF, 4'b0100);
    repeat (2) begin
      total++;
      if ({digit_en, seg_out, dp_out} !== exp_pins(16'h9999, 4'h0, k))
        $display("FAIL mid_slot_load got %h want %h", {digit_en, seg_out, dp_out}, exp_pins(16'h9999, 4'h0, k));
      else passed++;
      @(negedge clk);
    end
    test_scan("dash_dp", 16'h00AF, 4'b0100);
  endtask

  task automatic test_mid_slot_reset();
    int n;
    n = 0;
    while (!(digit_en === 4'hF && scan_idx === 2'd2) && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 40) $display("FAIL wait_slot2 got timeout want slot 2 within 40 cycles");
    else passed++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({scan_idx, digit_en, seg_out, dp_out} !== {2'd0, 4'hF, 7'h7F, 1'b1})
      $display("FAIL mid_reset got %h want %h", {scan_idx, digit_en, seg_out, dp_out}, {2'd0, 4'hF, 7'h7F, 1'b1});
    else passed++;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({scan_idx, digit_en, seg_out, dp_out} !== {2'd0, 4'hE, 7'h01, 1'b1})
        $display("FAIL restart_slot0 got %h want %h", {scan_idx, digit_en, seg_out, dp_out}, {2'd0, 4'hE, 7'h01, 1'b1});
      else passed++;
    end
  endtask

  task automatic test_leading_zeros();
    do_load(16'h0050, 4'h0);
    test_scan("lz_0050", 16'h0050, 4'h0);
    do_load(16'h0000, 4'h0);
    test_scan("lz_0000", 16'h0000, 4'h0);
  endtask

  initial begin
    rst    = 1'b1;
    load   = 1'b0;
    bcd_in = '0;
    dp_in  = '0;
    test_reset();
    do_load(16'h1234, 4'h0);
    test_scan("basic_1234", 16'h1234, 4'h0);
    test_no_tearing();
    test_dash_and_dp();
    test_mid_slot_reset();
    test_leading_zeros();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
